// File: rtl/conv_check.sv
// conv_check: serial max-magnitude scan of a 4x4 error matrix against a tolerance,
// with iteration counting, sticky timeout and a W_new snapshot for the controller.
`default_nettype none

module conv_check #(
  parameter int W        = 26,
  parameter int MAX_ITER = 64,
  parameter int ITER_W   = 7
) (
  input  logic              clk_conv,
  input  logic              rst_n_conv,
  input  logic              start_conv,
  input  logic              clear_iter,
  input  logic [W-1:0]      tol,
  input  logic [W-1:0]      i11, i12, i13, i14, i21, i22, i23, i24,
  input  logic [W-1:0]      i31, i32, i33, i34, i41, i42, i43, i44,
  input  logic [W-1:0]      iw_new11, iw_new12, iw_new13, iw_new14,
  input  logic [W-1:0]      iw_new21, iw_new22, iw_new23, iw_new24,
  input  logic [W-1:0]      iw_new31, iw_new32, iw_new33, iw_new34,
  input  logic [W-1:0]      iw_new41, iw_new42, iw_new43, iw_new44,
  output logic [W-1:0]      ow_new11, ow_new12, ow_new13, ow_new14,
  output logic [W-1:0]      ow_new21, ow_new22, ow_new23, ow_new24,
  output logic [W-1:0]      ow_new31, ow_new32, ow_new33, ow_new34,
  output logic [W-1:0]      ow_new41, ow_new42, ow_new43, ow_new44,
  output logic              busy,
  output logic              done,
  output logic              converged,
  output logic              timeout,
  output logic [W-1:0]      max_err,
  output logic [ITER_W-1:0] iter_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [ITER_W-1:0] ITER_LIM = ITER_W'(MAX_ITER);

  state_t       state;
  logic [W-1:0] err_in  [16];
  logic [W-1:0] wn_in   [16];
  logic [W-1:0] err_buf [16];
  logic [W-1:0] wn_buf  [16];
  logic [W-1:0] tol_q;
  logic [W-1:0] run_max;
  logic [W-1:0] cur_mag;
  logic [W-1:0] next_max;
  logic         next_conv;
  logic [3:0]   idx;

  assign err_in = '{i11, i12, i13, i14, i21, i22, i23, i24,
                    i31, i32, i33, i34, i41, i42, i43, i44};
  assign wn_in  = '{iw_new11, iw_new12, iw_new13, iw_new14,
                    iw_new21, iw_new22, iw_new23, iw_new24,
                    iw_new31, iw_new32, iw_new33, iw_new34,
                    iw_new41, iw_new42, iw_new43, iw_new44};

  assign ow_new11 = wn_buf[0];  assign ow_new12 = wn_buf[1];
  assign ow_new13 = wn_buf[2];  assign ow_new14 = wn_buf[3];
  assign ow_new21 = wn_buf[4];  assign ow_new22 = wn_buf[5];
  assign ow_new23 = wn_buf[6];  assign ow_new24 = wn_buf[7];
  assign ow_new31 = wn_buf[8];  assign ow_new32 = wn_buf[9];
  assign ow_new33 = wn_buf[10]; assign ow_new34 = wn_buf[11];
  assign ow_new41 = wn_buf[12]; assign ow_new42 = wn_buf[13];
  assign ow_new43 = wn_buf[14]; assign ow_new44 = wn_buf[15];

  // Negative values can arrive raw from an idle error stage; the most negative saturates.
  function automatic logic [W-1:0] mag(input logic [W-1:0] x);
    if (!x[W-1])
      return x;
    else if (x == {1'b1, {(W-1){1'b0}}})
      return {1'b0, {(W-1){1'b1}}};
    else
      return -x;
  endfunction

  always_comb begin
    cur_mag   = mag(err_buf[idx]);
    next_max  = (cur_mag > run_max) ? cur_mag : run_max;
    next_conv = (next_max <= tol_q);
  end

  always_ff @(posedge clk_conv or negedge rst_n_conv) begin
    if (!rst_n_conv) begin
      state     <= S_IDLE;
      for (int k = 0; k < 16; k++) begin
        err_buf[k] <= '0;
        wn_buf[k]  <= '0;
      end
      tol_q     <= '0;
      run_max   <= '0;
      idx       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      converged <= 1'b0;
      timeout   <= 1'b0;
      max_err   <= '0;
      iter_cnt  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_conv) begin
            for (int k = 0; k < 16; k++) begin
              err_buf[k] <= err_in[k];
              wn_buf[k]  <= wn_in[k];
            end
            tol_q   <= tol;
            run_max <= '0;
            idx     <= '0;
            busy    <= 1'b1;
            state   <= S_SCAN;
          end
        end
        S_SCAN: begin
          run_max <= next_max;
          idx     <= idx + 4'd1;
          if (idx == 4'd15) begin
            max_err   <= next_max;
            converged <= next_conv;
            done      <= 1'b1;
            state     <= S_DONE;
            if (next_conv) begin
              iter_cnt <= '0;
            end else if (iter_cnt < ITER_LIM) begin
              iter_cnt <= iter_cnt + ITER_W'(1);
              if (iter_cnt + ITER_W'(1) == ITER_LIM)
                timeout <= 1'b1;
            end
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
      // Placed last so a clear coincident with the final scan edge takes priority.
      if (clear_iter) begin
        iter_cnt <= '0;
        timeout  <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_conv_check.sv
// tb_conv_check: directed steps with a scoreboard of expected check results.
`default_nettype none

module tb_conv_check;
  localparam int W        = 26;
  localparam int MAX_ITER = 64;
  localparam int ITER_W   = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n, start, clr;
  logic [W-1:0]      tol;
  logic [W-1:0]      iv [16];
  logic [W-1:0]      wv [16];
  logic [W-1:0]      ow [16];
  logic              busy, done, conv, tmo;
  logic [W-1:0]      maxe;
  logic [ITER_W-1:0] iter;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [W-1:0]      mx;
    logic              cv;
    logic [ITER_W-1:0] it;
    logic              to;
    logic [16*W-1:0]   wn;
  } exp_t;

  exp_t sb[$];
  int   m_iter = 0;
  logic m_to = 1'b0;

  conv_check #(.W(W), .MAX_ITER(MAX_ITER), .ITER_W(ITER_W)) dut (
    .clk_conv(clk), .rst_n_conv(rst_n), .start_conv(start), .clear_iter(clr), .tol(tol),
    .i11(iv[0]),  .i12(iv[1]),  .i13(iv[2]),  .i14(iv[3]),
    .i21(iv[4]),  .i22(iv[5]),  .i23(iv[6]),  .i24(iv[7]),
    .i31(iv[8]),  .i32(iv[9]),  .i33(iv[10]), .i34(iv[11]),
    .i41(iv[12]), .i42(iv[13]), .i43(iv[14]), .i44(iv[15]),
    .iw_new11(wv[0]),  .iw_new12(wv[1]),  .iw_new13(wv[2]),  .iw_new14(wv[3]),
    .iw_new21(wv[4]),  .iw_new22(wv[5]),  .iw_new23(wv[6]),  .iw_new24(wv[7]),
    .iw_new31(wv[8]),  .iw_new32(wv[9]),  .iw_new33(wv[10]), .iw_new34(wv[11]),
    .iw_new41(wv[12]), .iw_new42(wv[13]), .iw_new43(wv[14]), .iw_new44(wv[15]),
    .ow_new11(ow[0]),  .ow_new12(ow[1]),  .ow_new13(ow[2]),  .ow_new14(ow[3]),
    .ow_new21(ow[4]),  .ow_new22(ow[5]),  .ow_new23(ow[6]),  .ow_new24(ow[7]),
    .ow_new31(ow[8]),  .ow_new32(ow[9]),  .ow_new33(ow[10]), .ow_new34(ow[11]),
    .ow_new41(ow[12]), .ow_new42(ow[13]), .ow_new43(ow[14]), .ow_new44(ow[15]),
    .busy(busy), .done(done), .converged(conv), .timeout(tmo),
    .max_err(maxe), .iter_cnt(iter)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference magnitude via wide signed arithmetic, clipped to the largest positive value.
  function automatic logic [W-1:0] ref_mag(input logic [W-1:0] x);
    longint v;
    longint lim;
    lim = (longint'(1) << (W-1)) - 1;
    v = longint'($signed(x));
    if (v < 0) v = -v;
    if (v > lim) v = lim;
    return W'(v);
  endfunction

  task automatic predict(input logic clr_at_end);
    exp_t e;
    logic [W-1:0] m;
    m = '0;
    for (int k = 0; k < 16; k++)
      if (ref_mag(iv[k]) > m) m = ref_mag(iv[k]);
    e.mx = m;
    e.cv = (m <= tol);
    if (e.cv) m_iter = 0;
    else if (m_iter < MAX_ITER) begin
      m_iter++;
      if (m_iter == MAX_ITER) m_to = 1'b1;
    end
    if (clr_at_end) begin
      m_iter = 0;
      m_to = 1'b0;
    end
    e.it = ITER_W'(m_iter);
    e.to = m_to;
    for (int k = 0; k < 16; k++) e.wn[k*W +: W] = wv[k];
    sb.push_back(e);
  endtask

  task automatic fill(input logic [W-1:0] v, input int wbase);
    for (int k = 0; k < 16; k++) begin
      iv[k] = v;
      wv[k] = W'(wbase * 16 + k + 1);
    end
  endtask

  task automatic check_zero(input string tag);
    logic [16*W-1:0] owp;
    for (int k = 0; k < 16; k++) owp[k*W +: W] = ow[k];
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_conv"}, conv, 0);
    chk({tag, "_timeout"}, tmo, 0);
    chk({tag, "_max_err"}, maxe, 0);
    chk({tag, "_iter"}, iter, 0);
    chk({tag, "_ow_any"}, |owp, 0);
  endtask

  task automatic run(input logic [W-1:0] t, input logic clr_e16, input logic disturb);
    int   n;
    exp_t e;
    @(negedge clk);
    tol = t;
    start = 1'b1;
    predict(clr_e16);
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    if (disturb) begin
      for (int k = 0; k < 16; k++) begin
        iv[k] = {1'b0, {(W-1){1'b1}}};
        wv[k] = ~wv[k];
      end
      tol = {W{1'b1}};
    end
    n = 0;
    while (!done && n < 40) begin
      if (disturb && n == 4) start = 1'b1;
      if (disturb && n == 6) start = 1'b0;
      if (clr_e16 && n == 15) clr = 1'b1;
      @(posedge clk); #1;
      n++;
      if (n == 16) clr = 1'b0;
    end
    clr = 1'b0;
    start = 1'b0;
    chk("done_latency", n, 16);
    e = sb.pop_front();
    if (done) begin
      chk("busy_with_done", busy, 1);
      chk("max_err", maxe, e.mx);
      chk("converged", conv, e.cv);
      chk("iter_cnt", iter, e.it);
      chk("timeout", tmo, e.to);
      for (int k = 0; k < 16; k++) chk($sformatf("ow_new[%0d]", k), ow[k], e.wn[k*W +: W]);
    end
    @(posedge clk); #1;
    chk("done_pulse_end", done, 0);
    chk("busy_end", busy, 0);
    if (disturb) begin
      @(posedge clk); #1;
      chk("no_queued_start", busy, 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; clr = 1'b0; tol = '0;
    fill(W'(26'h0001234), 3);
    repeat (2) @(posedge clk);
    #1 check_zero("reset");
    @(negedge clk) rst_n = 1'b1;

    fill(W'(26'h0400), 1);          run(W'(26'h0800), 1'b0, 1'b0);
    fill(W'(26'h0100), 2);          iv[11] = W'(26'h3000); run(W'(26'h2000), 1'b0, 1'b0);
    fill(W'(26'h0100), 3);          iv[15] = W'(26'h3000); run(W'(26'h2000), 1'b0, 1'b0);
    fill(W'(26'h0100), 4);          iv[6]  = W'(26'h2000); run(W'(26'h2000), 1'b0, 1'b0);
    fill(W'(26'h0100), 5);          iv[6]  = W'(26'h2000); run(W'(26'h1FFF), 1'b0, 1'b0);
    fill('0, 6);                    iv[0]  = -W'(26'h1800); run('0, 1'b0, 1'b0);
    fill('0, 7);                    iv[0]  = {1'b1, {(W-1){1'b0}}}; run('0, 1'b0, 1'b0);

    // Reset asserted right after the eighth scan edge of a running check.
    fill(W'(26'h0500), 8);
    @(negedge clk); tol = '0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (8) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check_zero("mid_scan_reset");
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (done !== 1'b0) chk("no_done_in_reset", done, 0);
    end
    chk("done_low_after_reset", done, 0);
    @(negedge clk) rst_n = 1'b1;
    m_iter = 0; m_to = 1'b0;

    fill(W'(26'h0200), 9);          run(W'(26'h0100), 1'b0, 1'b1);
    for (int r = 2; r <= MAX_ITER; r++) begin
      fill(W'(26'h0300), 10 + r);   run(W'(26'h0100), 1'b0, 1'b0);
    end
    chk("timeout_at_64", tmo, 1);
    chk("iter_at_64", iter, 64);
    fill(W'(26'h0300), 90);         run(W'(26'h0100), 1'b0, 1'b0);
    chk("iter_saturated", iter, 64);
    fill(W'(26'h0300), 91);         run(W'(26'h0100), 1'b1, 1'b0);
    chk("iter_cleared", iter, 0);
    chk("timeout_cleared", tmo, 0);
    fill(W'(26'h0010), 92);         run(W'(26'h0100), 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
